// File: rtl/conv_pkg.sv
// Shared types and Q1.15 helpers for the per-channel convolution sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RUN,
        S_ACCUM,
        S_OUTPUT
    } state_t;

    localparam logic [15:0] Q15_MAX = 16'h7FFF;
    localparam logic [15:0] Q15_MIN = 16'h8000;

    // Returns {overflow, clamped}; overflow when the 17-bit sum's top two bits differ.
    function automatic logic [16:0] sat16(input logic [16:0] s);
        logic [16:0] r;
        if (s[16] != s[15])
            r = {1'b1, (s[16] ? Q15_MIN : Q15_MAX)};
        else
            r = {1'b0, s[15:0]};
        return r;
    endfunction

endpackage

// File: rtl/fm_accumulator.sv
// Three OP_SIZE x OP_SIZE Q1.15 accumulators with per-element saturating adders.
module fm_accumulator
    import conv_pkg::*;
#(
    parameter int OP_SIZE = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_first,
    input  logic                      accumulate,
    input  logic [16*OP_SIZE*OP_SIZE-1:0] ik1,
    input  logic [16*OP_SIZE*OP_SIZE-1:0] ik2,
    input  logic [16*OP_SIZE*OP_SIZE-1:0] ik3,
    output logic [16*OP_SIZE*OP_SIZE-1:0] fm1,
    output logic [16*OP_SIZE*OP_SIZE-1:0] fm2,
    output logic [16*OP_SIZE*OP_SIZE-1:0] fm3,
    output logic                      sat_hit
);

    localparam int NE = OP_SIZE * OP_SIZE;

    logic [2:0][NE-1:0][15:0] ik;
    logic [2:0][NE-1:0][15:0] acc;
    logic [2:0][NE-1:0]       ovf;

    assign ik  = {ik3, ik2, ik1};
    assign fm1 = acc[0];
    assign fm2 = acc[1];
    assign fm3 = acc[2];

    for (genvar m = 0; m < 3; m++) begin : g_map
        for (genvar e = 0; e < NE; e++) begin : g_el
            logic [16:0] sum;
            logic [16:0] clamped;
            logic [15:0] acc_q;

            assign sum     = {ik[m][e][15], ik[m][e]} + {acc_q[15], acc_q};
            assign clamped = sat16(sum);
            // The first channel overwrites, so a stale sum must not flag saturation.
            assign ovf[m][e] = clamped[16] & ~load_first;
            assign acc[m][e] = acc_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    acc_q <= '0;
                else if (accumulate)
                    acc_q <= load_first ? ik[m][e] : clamped[15:0];
            end
        end
    end

    assign sat_hit = accumulate & (|ovf);

endmodule

// File: rtl/conv_channel_sequencer.sv
// Runs the 3-kernel engine once per input channel and sums partial maps into the layer output.
module conv_channel_sequencer
    import conv_pkg::*;
#(
    parameter  int IP_SIZE     = 6,
    parameter  int KERNEL_SIZE = 3,
    parameter  int MAX_CH      = 8,
    parameter  int TIMEOUT     = 64,
    localparam int OP_SIZE     = IP_SIZE - KERNEL_SIZE + 1,
    localparam int CH_W        = $clog2(MAX_CH + 1),
    localparam int IP_W        = 16 * IP_SIZE * IP_SIZE,
    localparam int K_W         = 16 * KERNEL_SIZE * KERNEL_SIZE,
    localparam int M_W         = 16 * OP_SIZE * OP_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CH_W-1:0] num_ch,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            sat,
    output logic            fetch_req,
    output logic [CH_W-1:0] fetch_ch,
    input  logic            fetch_valid,
    input  logic [IP_W-1:0] fetch_ip,
    input  logic [K_W-1:0]  fetch_k1,
    input  logic [K_W-1:0]  fetch_k2,
    input  logic [K_W-1:0]  fetch_k3,
    output logic            eng_rst,
    output logic [IP_W-1:0] eng_ipf,
    output logic [K_W-1:0]  eng_k1f,
    output logic [K_W-1:0]  eng_k2f,
    output logic [K_W-1:0]  eng_k3f,
    input  logic            eng_resting,
    input  logic [M_W-1:0]  eng_ik1,
    input  logic [M_W-1:0]  eng_ik2,
    input  logic [M_W-1:0]  eng_ik3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [M_W-1:0]  fm1,
    output logic [M_W-1:0]  fm2,
    output logic [M_W-1:0]  fm3
);

    localparam int TC_W = $clog2(TIMEOUT + 1);

    state_t          state, next_state;
    logic [CH_W-1:0] ch, num_ch_q, ch_inc;
    logic [TC_W-1:0] tcnt;
    logic            start_ok, xfer, sat_hit, timeout_hit;

    assign ch_inc      = ch + 1'b1;
    assign start_ok    = (num_ch != '0) && (num_ch <= CH_W'(MAX_CH));
    assign xfer        = fetch_req & fetch_valid;
    assign timeout_hit = (tcnt == TC_W'(TIMEOUT - 1));

    assign busy      = (state != S_IDLE);
    assign fetch_req = (state == S_FETCH);
    assign fetch_ch  = ch;
    assign out_valid = (state == S_OUTPUT);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start && start_ok) next_state = S_FETCH;
            S_FETCH:  if (fetch_valid) next_state = S_RUN;
            S_RUN: begin
                // A finishing engine beats a timeout landing on the same cycle.
                if (eng_resting)      next_state = S_ACCUM;
                else if (timeout_hit) next_state = S_IDLE;
            end
            S_ACCUM:  next_state = (ch_inc == num_ch_q) ? S_OUTPUT : S_FETCH;
            S_OUTPUT: if (out_ready) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ch       <= '0;
            num_ch_q <= '0;
            tcnt     <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            sat      <= 1'b0;
            eng_rst  <= 1'b1;
        end else begin
            state   <= next_state;
            eng_rst <= (next_state != S_RUN);
            done    <= ((state == S_RUN) || (state == S_OUTPUT)) && (next_state == S_IDLE);
            err     <= ((state == S_IDLE) && start && !start_ok) ||
                       ((state == S_RUN) && (next_state == S_IDLE));
            tcnt    <= (state == S_RUN) ? tcnt + 1'b1 : '0;
            if ((state == S_IDLE) && start && start_ok) begin
                ch       <= '0;
                num_ch_q <= num_ch;
                sat      <= 1'b0;
            end
            if (state == S_ACCUM) begin
                ch <= ch_inc;
                if (sat_hit) sat <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_ipf <= '0;
            eng_k1f <= '0;
            eng_k2f <= '0;
            eng_k3f <= '0;
        end else if (xfer) begin
            eng_ipf <= fetch_ip;
            eng_k1f <= fetch_k1;
            eng_k2f <= fetch_k2;
            eng_k3f <= fetch_k3;
        end
    end

    fm_accumulator #(.OP_SIZE(OP_SIZE)) u_acc (
        .clk        (clk),
        .rst        (rst),
        .load_first (ch == '0),
        .accumulate (state == S_ACCUM),
        .ik1        (eng_ik1),
        .ik2        (eng_ik2),
        .ik3        (eng_ik3),
        .fm1        (fm1),
        .fm2        (fm2),
        .fm3        (fm3),
        .sat_hit    (sat_hit)
    );

endmodule
